bank_counter_array_v2: RTL
==========================

Name: bank_counter_array_v2

Overview:
- Parametrised, multi-channel successor to the per-column bank counter.
- Captures the comparator outputs (clp/cln) of N_CH columns on each sense-amp latch strobe and accumulates a signed difference or a popcount per column over a programmed number of samples.
- Supports per-column early-termination freeze, saturating arithmetic and a self-sequencing controller.
- Publishes results through a double-buffered valid/ready output. Sits between the analog SA/comparator array and the digital readout / next-layer logic.

Parameters:
- N_CH, 32: number of columns (lanes).
- CTR_W, 8: signed width of each bank counter and of each output word.
- MAX_SAMPLES, 255: largest programmable sample count.
- SCNT_W, $clog2(MAX_SAMPLES+1): width of NUM_SAMPLES and of the internal sample counter.

Ports:
- CLK  in  1  clock.
- RESET  in  1  synchronous, active-high reset.
- START  in  1  one-cycle pulse; begins a conversion; honoured only in IDLE.
- NUM_SAMPLES  in  SCNT_W  number of accumulated samples; captured at START.
- COMP_POSITIVE_PHASE  in  1  1: delta = clp-cln; 0: delta = cln-clp; captured at START.
- MODE_POPCOUNT  in  1  1: delta = +1 if clp else 0 (phase ignored); captured at START.
- SA_LATCH  in  1  sample strobe from the SA timing block.
- ET_TRIGG  in  N_CH  per-column early-termination freeze (level).
- CLP  in  N_CH  comparator positive outputs.
- CLN  in  N_CH  comparator negative outputs.
- OUT_READY  in  1  consumer accepts the output buffer.
- BANK_CTR_LATCHED  out  N_CH*CTR_W  output buffer; lane k in bits [k*CTR_W +: CTR_W], two's complement.
- SAT_FLAGS  out  N_CH  per-lane saturation flag, buffered with the data.
- OUT_VALID  out  1  output buffer holds unconsumed data.
- OVERRUN  out  1  sticky; a new result overwrote unconsumed data.
- BUSY  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset: all outputs, counters, capture registers and flags go to 0; FSM goes to IDLE. Reset mid-conversion aborts the conversion with no output.
- FSM states: IDLE, ACCUM, LATCH.
- IDLE -> ACCUM on START. At the same edge:
  - clear all lane counters and sat flags;
  - clear the sample counter;
  - capture NUM_SAMPLES and the mode bits.
- IDLE -> LATCH directly on START with NUM_SAMPLES==0, producing all-zero results.
- START outside IDLE is ignored.
- ACCUM, capture stage (edge t): on SA_LATCH, each lane with ET_TRIGG=0 registers CLP/CLN. Lanes with ET_TRIGG=1 hold their previous capture.
- ACCUM, add stage (edge t+1): a registered add_pending bit drives the addition. Every non-frozen lane does counter <= sat(counter + delta), and the sample counter increments by 1 (global, regardless of freezes).
- Delta values: -1, 0 or +1, sign-extended to CTR_W+1 bits before the add.
- Back-to-back SA_LATCH strobes (every cycle) are supported at full rate.
- When the incremented sample count equals NUM_SAMPLES, the next state is LATCH. Further SA_LATCH strobes in that cycle are ignored.
- SA_LATCH in IDLE or LATCH is ignored.
- Saturation: results clamp to +2^(CTR_W-1)-1 and -2^(CTR_W-1). The lane's sat flag sets on the clamp and is sticky until the next START.
- LATCH (one cycle): copy all counters and sat flags into the output buffer, set OUT_VALID, go to IDLE.
- If OUT_VALID=1 and OUT_READY=0 at that edge, the buffer is still overwritten and OVERRUN sets. OVERRUN clears only on RESET.
- Handshake: OUT_VALID clears on the edge where OUT_VALID & OUT_READY, unless LATCH loads new data at the same edge, in which case OUT_VALID stays 1 with no overrun.
- BANK_CTR_LATCHED is stable while OUT_VALID=1, except on an overrun.
- A new conversion may start while OUT_VALID=1 (double buffering).
- Latency: last SA_LATCH at edge t -> counters final at t+1 -> LATCH state at t+1..t+2 -> OUT_VALID high after edge t+2.

Decomposition:
- Shared package: FSM state encoding, default N_CH, CTR_W and MAX_SAMPLES, and the lane-bit-slicing convention for flattened buses.
- Sub-module bank_counter_lane: one column. Contains the capture register, freeze, delta generation and the saturating CTR_W counter with its sat flag.
- The top level holds the FSM, sample counter, add_pending, mode registers, output buffer and handshake, and instantiates N_CH lanes with a generate loop.

Test Plan:
- N_CH=4, CTR_W=8, NUM_SAMPLES=5, phase=1, CLP=4'b0101, CLN=4'b0011, 5 back-to-back SA_LATCH -> lanes {0,-5,+5,0} (lane0 first); OUT_VALID 2 cycles after the last strobe; BUSY low afterwards.
- Same stimulus with phase=0 -> {0,+5,-5,0}. MODE_POPCOUNT=1 -> {5,0,5,0}.
- ET_TRIGG[2] asserted after the 2nd of 5 samples, first test's stimulus -> lane2=+2, other lanes unchanged from that test; no sat.
- CTR_W=6, NUM_SAMPLES=40, CLP=all 1, CLN=all 0 -> every lane = +31 and SAT_FLAGS=4'hF. Next START with CLP=0 restarts from 0 with flags clear.
- OUT_READY held 0 across two conversions -> second result visible and OVERRUN=1. OUT_READY pulsed in the same cycle as the next LATCH -> OUT_VALID stays 1 and OVERRUN stays 0.
- RESET pulse on the 3rd sample of a NUM_SAMPLES=10 run -> all outputs 0, IDLE, and no OUT_VALID; NUM_SAMPLES=0 START -> zeros valid 2 cycles later.

Source files
------------

// File: rtl/bank_counter_array_v2_pkg.sv
// Shared definitions for the multi-channel bank counter array:
// controller state encoding, default geometry and the lane slicing
// rule used for every flattened per-lane bus.
package bank_counter_array_v2_pkg;

    localparam int DEF_N_CH        = 32;
    localparam int DEF_CTR_W       = 8;
    localparam int DEF_MAX_SAMPLES = 255;

    // Controller states
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_LATCH = 2'd2;

    // Lane k of a flattened bus occupies bits [lane_lsb(k, w) +: w]
    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/bank_counter_array_v2_lane.sv
// One column of the bank counter array: comparator capture register with
// early-termination freeze, delta generation and a saturating signed
// counter with a sticky saturation flag.
module bank_counter_lane
    import bank_counter_array_v2_pkg::*;
#(
    parameter int CTR_W = DEF_CTR_W
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             CLEAR,
    input  logic             CAPTURE,
    input  logic             ADD,
    input  logic             PHASE,
    input  logic             POPCOUNT,
    input  logic             ET_TRIGG,
    input  logic             CLP,
    input  logic             CLN,
    output logic [CTR_W-1:0] COUNT,
    output logic             SAT
);

    logic             clp_r;
    logic             cln_r;
    logic             add_en_r;   // the held capture belongs to an unfrozen sample
    logic [CTR_W-1:0] count_r;
    logic             sat_r;

    logic             pos_s;
    logic             neg_s;
    logic [CTR_W:0]   delta_s;
    logic [CTR_W:0]   sum_s;
    logic [CTR_W-1:0] next_s;
    logic             ovf_s;

    // Capture the comparator pair on a strobe; a frozen lane keeps its old capture
    always_ff @(posedge CLK) begin
        if (RESET) begin
            clp_r    <= 1'b0;
            cln_r    <= 1'b0;
            add_en_r <= 1'b0;
        end else if (CLEAR) begin
            clp_r    <= 1'b0;
            cln_r    <= 1'b0;
            add_en_r <= 1'b0;
        end else if (CAPTURE) begin
            if (!ET_TRIGG) begin
                clp_r    <= CLP;
                cln_r    <= CLN;
                add_en_r <= 1'b1;
            end else begin
                add_en_r <= 1'b0;
            end
        end
    end

    // Delta of -1/0/+1 in CTR_W+1 bits, then a saturating add
    always_comb begin
        pos_s   = 1'b0;
        neg_s   = 1'b0;
        delta_s = {(CTR_W+1){1'b0}};
        if (POPCOUNT) begin
            pos_s = clp_r;
        end else if (PHASE) begin
            pos_s = clp_r & ~cln_r;
            neg_s = cln_r & ~clp_r;
        end else begin
            pos_s = cln_r & ~clp_r;
            neg_s = clp_r & ~cln_r;
        end
        if (pos_s) begin
            delta_s = {{CTR_W{1'b0}}, 1'b1};
        end else if (neg_s) begin
            delta_s = {(CTR_W+1){1'b1}};
        end else begin
            delta_s = {(CTR_W+1){1'b0}};
        end
        sum_s = {count_r[CTR_W-1], count_r} + delta_s;
        // Overflow when the two top bits of the widened sum disagree
        ovf_s = sum_s[CTR_W] ^ sum_s[CTR_W-1];
        if (ovf_s) begin
            if (sum_s[CTR_W]) begin
                next_s = {1'b1, {(CTR_W-1){1'b0}}};
            end else begin
                next_s = {1'b0, {(CTR_W-1){1'b1}}};
            end
        end else begin
            next_s = sum_s[CTR_W-1:0];
        end
    end

    // Accumulate one sample per pending add unless this lane's sample was frozen
    always_ff @(posedge CLK) begin
        if (RESET) begin
            count_r <= {CTR_W{1'b0}};
            sat_r   <= 1'b0;
        end else if (CLEAR) begin
            count_r <= {CTR_W{1'b0}};
            sat_r   <= 1'b0;
        end else if (ADD && add_en_r) begin
            count_r <= next_s;
            sat_r   <= sat_r | ovf_s;
        end
    end

    assign COUNT = count_r;
    assign SAT   = sat_r;

endmodule

// File: rtl/bank_counter_array_v2.sv
// Multi-channel bank counter array: self-sequencing conversion controller,
// global sample counter, N_CH accumulating lanes and a double-buffered
// valid/ready result register with sticky overrun detection.
module bank_counter_array_v2
    import bank_counter_array_v2_pkg::*;
#(
    parameter int N_CH        = DEF_N_CH,
    parameter int CTR_W       = DEF_CTR_W,
    parameter int MAX_SAMPLES = DEF_MAX_SAMPLES,
    parameter int SCNT_W      = $clog2(MAX_SAMPLES + 1)
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    START,
    input  logic [SCNT_W-1:0]       NUM_SAMPLES,
    input  logic                    COMP_POSITIVE_PHASE,
    input  logic                    MODE_POPCOUNT,
    input  logic                    SA_LATCH,
    input  logic [N_CH-1:0]         ET_TRIGG,
    input  logic [N_CH-1:0]         CLP,
    input  logic [N_CH-1:0]         CLN,
    input  logic                    OUT_READY,
    output logic [N_CH*CTR_W-1:0]   BANK_CTR_LATCHED,
    output logic [N_CH-1:0]         SAT_FLAGS,
    output logic                    OUT_VALID,
    output logic                    OVERRUN,
    output logic                    BUSY
);

    logic [1:0]              state_r;
    logic [1:0]              state_nxt_s;
    logic                    busy_r;
    logic [SCNT_W-1:0]       scnt_r;
    logic [SCNT_W-1:0]       num_r;
    logic                    phase_r;
    logic                    pop_r;
    logic                    add_pending_r;

    logic                    start_s;
    logic                    last_add_s;
    logic                    capture_s;

    logic [N_CH*CTR_W-1:0]   count_flat_s;
    logic [N_CH-1:0]         lane_sat_s;

    logic [N_CH*CTR_W-1:0]   out_data_r;
    logic [N_CH-1:0]         out_sat_r;
    logic                    out_valid_r;
    logic                    overrun_r;

    // Control decode and next-state selection
    always_comb begin
        start_s    = (state_r == ST_IDLE) && START;
        // The add in flight is the final one of this conversion
        last_add_s = add_pending_r &&
                     (({1'b0, scnt_r} + {{SCNT_W{1'b0}}, 1'b1}) == {1'b0, num_r});
        capture_s  = (state_r == ST_ACCUM) && SA_LATCH && !last_add_s;
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (START) begin
                    if (NUM_SAMPLES == {SCNT_W{1'b0}}) begin
                        state_nxt_s = ST_LATCH;
                    end else begin
                        state_nxt_s = ST_ACCUM;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                if (last_add_s) begin
                    state_nxt_s = ST_LATCH;
                end else begin
                    state_nxt_s = ST_ACCUM;
                end
            end
            ST_LATCH: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Controller state, conversion settings, sample counter and add pipeline
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r       <= ST_IDLE;
            busy_r        <= 1'b0;
            scnt_r        <= {SCNT_W{1'b0}};
            num_r         <= {SCNT_W{1'b0}};
            phase_r       <= 1'b0;
            pop_r         <= 1'b0;
            add_pending_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s != ST_IDLE);
            if (start_s) begin
                scnt_r        <= {SCNT_W{1'b0}};
                num_r         <= NUM_SAMPLES;
                phase_r       <= COMP_POSITIVE_PHASE;
                pop_r         <= MODE_POPCOUNT;
                add_pending_r <= 1'b0;
            end else begin
                if (add_pending_r) begin
                    scnt_r <= scnt_r + {{(SCNT_W-1){1'b0}}, 1'b1};
                end
                add_pending_r <= capture_s;
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < N_CH; g++) begin : g_lane
            bank_counter_lane #(
                .CTR_W (CTR_W)
            ) u_lane (
                .CLK      (CLK),
                .RESET    (RESET),
                .CLEAR    (start_s),
                .CAPTURE  (capture_s),
                .ADD      (add_pending_r),
                .PHASE    (phase_r),
                .POPCOUNT (pop_r),
                .ET_TRIGG (ET_TRIGG[g]),
                .CLP      (CLP[g]),
                .CLN      (CLN[g]),
                .COUNT    (count_flat_s[lane_lsb(g, CTR_W) +: CTR_W]),
                .SAT      (lane_sat_s[g])
            );
        end
    endgenerate

    // Output buffer: load on LATCH (flagging overwrite of unread data), drop valid on handshake
    always_ff @(posedge CLK) begin
        if (RESET) begin
            out_data_r  <= {(N_CH*CTR_W){1'b0}};
            out_sat_r   <= {N_CH{1'b0}};
            out_valid_r <= 1'b0;
            overrun_r   <= 1'b0;
        end else if (state_r == ST_LATCH) begin
            out_data_r  <= count_flat_s;
            out_sat_r   <= lane_sat_s;
            out_valid_r <= 1'b1;
            if (out_valid_r && !OUT_READY) begin
                overrun_r <= 1'b1;
            end
        end else if (out_valid_r && OUT_READY) begin
            out_valid_r <= 1'b0;
        end
    end

    assign BANK_CTR_LATCHED = out_data_r;
    assign SAT_FLAGS        = out_sat_r;
    assign OUT_VALID        = out_valid_r;
    assign OVERRUN          = overrun_r;
    assign BUSY             = busy_r;

endmodule
